// File: rtl/oric_ram_port_arbiter.sv
// oric_ram_port_arbiter
//   Sole owner of the main-RAM port. Merges CPU accesses with the cassette loader's tape
//   byte writes into one registered RAM port. Performs the power-on fill sweep when the
//   RAM_CLEAR_EN macro is defined. Tape writes are buffered in a small FIFO while the CPU
//   owns the port.
//
//   Build option: RAM_CLEAR_EN
//     defined   - CLEAR state, clear counter and clear_req_i are active. Reset starts a
//                 sweep writing FILL_VALUE to every address.
//     undefined - starts directly in RUN; clr_busy_o is tied low and clear_req_i is ignored.
//
// Ports
//   clk_48_i     system clock, rising edge
//   reset_i      asynchronous active-high reset
//   clear_req_i  1-cycle pulse restarting the RAM clear sweep
//   cpu_*        CPU address, write data, chip select, write enable; cpu_q_o read data
//   tape_*       loader write address, data and 1-cycle strobe (no backpressure)
//   mem_*        registered RAM port (address, data, enable, write enable); mem_q_i read data
//   clr_busy_o   clear sweep in progress
//   fifo_ovf_o   sticky flag: a tape write was dropped because the FIFO was full

module oric_ram_port_arbiter #(
  parameter int unsigned AW         = 16,
  parameter logic [7:0]  FILL_VALUE = 8'h01,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk_48_i,
  input  logic          reset_i,
  input  logic          clear_req_i,
  input  logic [AW-1:0] cpu_ad_i,
  input  logic [7:0]    cpu_d_i,
  input  logic          cpu_cs_i,
  input  logic          cpu_we_i,
  output logic [7:0]    cpu_q_o,
  input  logic [AW-1:0] tape_addr_i,
  input  logic [7:0]    tape_dout_i,
  input  logic          tape_wr_i,
  output logic [AW-1:0] mem_a_o,
  output logic [7:0]    mem_d_o,
  output logic          mem_ce_o,
  output logic          mem_we_o,
  input  logic [7:0]    mem_q_i,
  output logic          clr_busy_o,
  output logic          fifo_ovf_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PtrOne  = PW'(1);
  localparam logic [PW:0]   CntOne  = (PW + 1)'(1);
  localparam logic [PW:0]   CntFull = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StClear, StRun} state_e;

`ifdef RAM_CLEAR_EN
  localparam state_e StReset       = StClear;
  localparam logic   ClrBusyReset  = 1'b1;
`else
  localparam state_e StReset       = StRun;
  localparam logic   ClrBusyReset  = 1'b0;
  logic unused_clear_req;
  assign unused_clear_req = clear_req_i;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [7:0]    mem_d_q, mem_d_d;
  logic          mem_ce_q, mem_ce_d;
  logic          mem_we_q, mem_we_d;
  logic          clr_busy_q, clr_busy_d;
  // port_clr_q: the current port cycle is a clear write; fill_q: its read data is due now
  logic          port_clr_q, port_clr_d;
  logic          fill_q;

`ifdef RAM_CLEAR_EN
  logic [AW-1:0] cnt_q, cnt_d;
`endif

  // Tape write FIFO
  logic [AW-1:0] fifo_a_q [FIFO_DEPTH];
  logic [7:0]    fifo_d_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          fifo_ovf_q;
  logic          fifo_empty, fifo_full;
  logic          pop, push_ok, drop, flush;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntFull);

  // A push into a full FIFO is still accepted when the same cycle pops an entry.
  assign push_ok = tape_wr_i && (!fifo_full || pop) && !flush;
  assign drop    = tape_wr_i && fifo_full && !pop && !flush;

  always_comb begin
    state_d    = state_q;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
    mem_ce_d   = 1'b0;
    mem_we_d   = 1'b0;
    port_clr_d = 1'b0;
    clr_busy_d = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
`ifdef RAM_CLEAR_EN
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      StClear: begin
`ifdef RAM_CLEAR_EN
        // CPU accesses are ignored; the sweep owns the port.
        mem_ce_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_a_d    = cnt_q;
        mem_d_d    = FILL_VALUE;
        port_clr_d = 1'b1;
        clr_busy_d = 1'b1;
        cnt_d      = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) begin
          state_d = StRun;
        end
`else
        state_d = StRun;
`endif
      end
      StRun: begin
        if (cpu_cs_i) begin
          mem_ce_d = 1'b1;
          mem_we_d = cpu_we_i;
          mem_a_d  = cpu_ad_i;
          mem_d_d  = cpu_d_i;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          mem_ce_d = 1'b1;
          mem_we_d = 1'b1;
          mem_a_d  = fifo_a_q[rd_ptr_q];
          mem_d_d  = fifo_d_q[rd_ptr_q];
        end
      end
      default: state_d = StRun;
    endcase

`ifdef RAM_CLEAR_EN
    // Restart overrides everything this cycle, including any pop or push.
    if (clear_req_i) begin
      state_d    = StClear;
      cnt_d      = '0;
      mem_ce_d   = 1'b0;
      mem_we_d   = 1'b0;
      port_clr_d = 1'b0;
      clr_busy_d = 1'b1;
      pop        = 1'b0;
      flush      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_48_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StReset;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      clr_busy_q <= ClrBusyReset;
      port_clr_q <= 1'b0;
      fill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      clr_busy_q <= clr_busy_d;
      port_clr_q <= port_clr_d;
      fill_q     <= port_clr_q;
    end
  end

`ifdef RAM_CLEAR_EN
  always_ff @(posedge clk_48_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk_48_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_ovf_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_ovf_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        fifo_ovf_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk_48_i) begin
    if (push_ok) begin
      fifo_a_q[wr_ptr_q] <= tape_addr_i;
      fifo_d_q[wr_ptr_q] <= tape_dout_i;
    end
  end

  assign mem_a_o    = mem_a_q;
  assign mem_d_o    = mem_d_q;
  assign mem_ce_o   = mem_ce_q;
  assign mem_we_o   = mem_we_q;
  assign clr_busy_o = clr_busy_q;
  assign fifo_ovf_o = fifo_ovf_q;
  // Reads issued while the sweep owns the port return the fill byte.
  assign cpu_q_o    = fill_q ? FILL_VALUE : mem_q_i;

endmodule
